jelly3_img_demosaic_acpi_seq: RTL and testbench
===============================================

JELLY3_IMG_DEMOSAIC_ACPI_SEQ -- requirements
Module: jelly3_img_demosaic_acpi_seq

Interface
REQ-001 Parameter LATENCY, default 7, SHALL be the datapath pipeline depth in cke-qualified cycles.
REQ-002 Parameter FRAME_CNT_BITS, default 16, SHALL be the frame counter width.
REQ-003 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset_n  in  1  SHALL be the reset, asynchronous assert, active-low.
REQ-005 param_phase  in  2  SHALL be the requested Bayer phase.
REQ-006 param_update  in  1  SHALL be a level enabling shadow load of param_phase at frame start.
REQ-007 s_valid / s_ready  in / out  1 / 1  SHALL be the input handshake.
REQ-008 s_line_first, s_pixel_first, s_last  in  1 each  SHALL be the input frame markers.
REQ-009 dp_cke  out  1  SHALL drive the datapath clock enable.
REQ-010 dp_line_first, dp_pixel_first  out  1 each  SHALL be the markers presented to the datapath.
REQ-011 dp_param_phase  out  2  SHALL be the active shadow phase.
REQ-012 m_valid / m_ready  out / in  1 / 1  SHALL be the output handshake.
REQ-013 m_line_first, m_pixel_first, m_last  out  1 each  SHALL be the markers aligned to datapath output.
REQ-014 busy  out  1  SHALL indicate the FSM is not IDLE.
REQ-015 frame_count  out  FRAME_CNT_BITS  SHALL count completed frames.

Function
REQ-016 dp_cke SHALL equal m_ready OR NOT m_valid; s_ready SHALL equal dp_cke.
REQ-017 On dp_cke, a LATENCY-deep sideband pipe SHALL shift {s_valid, markers}; m_* SHALL be its tail.
REQ-018 dp_line_first/dp_pixel_first SHALL be s_line_first/s_pixel_first gated by s_valid.
REQ-019 Shadow dp_param_phase SHALL load param_phase on an accepted beat with s_line_first and s_pixel_first set while param_update=1; otherwise it SHALL hold.
REQ-020 FSM states: IDLE, ACTIVE, DRAIN.
REQ-021 IDLE->ACTIVE on an accepted beat with s_line_first and s_pixel_first set; other accepted beats in IDLE SHALL pass through without a state change.
REQ-022 ACTIVE->DRAIN on an accepted beat with s_last=1; a simultaneous frame-start and last beat SHALL go directly to DRAIN.
REQ-023 DRAIN->IDLE when no sideband stage holds a beat carrying a marker of the drained frame (pipe valid bits all zero).
REQ-024 A new frame start accepted in DRAIN SHALL go to ACTIVE and SHALL NOT wait for drain.
REQ-025 frame_count SHALL increment by 1, wrapping modulo 2^FRAME_CNT_BITS, when a beat with m_last=1 is transferred (m_valid AND m_ready).
REQ-026 m_valid SHALL rise exactly LATENCY cke cycles after the corresponding s_valid&s_ready; it SHALL hold with stable markers while m_ready=0.

Reset
REQ-027 Under reset_n=0: FSM=IDLE, sideband pipe cleared, m_valid=0, m_* markers=0, dp_param_phase=param_phase sampled 0 (2'b00), frame_count=0, busy=0.
REQ-028 reset_n assertion mid-frame SHALL discard all in-flight beats; no m_valid SHALL occur until a new input is accepted after release.

Configuration
REQ-029 Macro JELLY3_IMG_DEMOSAIC_SEQ_FRAME_COUNT_EN SHALL compile in the frame counter of REQ-025.
REQ-030 Without the macro, frame_count SHALL be tied to 0 and no counter register SHALL be instantiated; all other behaviour SHALL be identical.

Structure
REQ-031 Package jelly3_img_demosaic_pkg SHALL hold phase_t (2 bits), the FSM state enum, and the default LATENCY constant 7.
REQ-032 Sub-module jelly3_img_demosaic_sideband_pipe SHALL implement the cke-gated valid/marker delay line of REQ-017.

Verification
REQ-033 4x2 frame, m_ready=1, first beat accepted at cycle 10 -> m_valid first at cycle 17 with m_line_first=m_pixel_first=1; m_last on 8th output beat; frame_count 0->1.
REQ-034 m_ready=0 for 5 cycles mid-frame -> dp_cke=0 and s_ready=0 once m_valid=1; m_* stable; no beat lost or duplicated.
REQ-035 param_phase=2'b11, param_update=1 at frame start -> dp_param_phase=2'b11; changing param_phase to 2'b01 mid-frame -> dp_param_phase unchanged until next frame start.
REQ-036 Frame B start accepted while FSM=DRAIN for frame A -> state ACTIVE on next cycle; frame_count reaches 2 after both m_last transfers.
REQ-037 reset_n low for 1 cycle with 3 beats in flight -> m_valid=0, busy=0, frame_count=0 thereafter; no stale output.
REQ-038 Build without JELLY3_IMG_DEMOSAIC_SEQ_FRAME_COUNT_EN, rerun REQ-033 -> identical m_* trace, frame_count constant 0.

Source files
------------

// File: rtl/jelly3_img_demosaic_pkg.sv
// Shared types and constants for the jelly3 demosaic sequencer.
package jelly3_img_demosaic_pkg;

  localparam int DEFAULT_LATENCY = 7;

  typedef logic [1:0] phase_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  function automatic logic is_frame_start(input logic accept, input logic line_first,
                                          input logic pixel_first);
    return accept & line_first & pixel_first;
  endfunction

endpackage

// File: rtl/jelly3_img_demosaic_sideband_pipe.sv
// Clock-enable gated delay line carrying beat valid and frame markers
// alongside the demosaic datapath.
module jelly3_img_demosaic_sideband_pipe #(
  parameter int LATENCY     = 7,
  parameter int MARKER_BITS = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cke,
  input  logic                   in_valid,
  input  logic [MARKER_BITS-1:0] in_marker,
  output logic                   out_valid,
  output logic [MARKER_BITS-1:0] out_marker,
  output logic                   any_valid
);

  logic [LATENCY-1:0]     valid_r;
  logic [MARKER_BITS-1:0] marker_r [LATENCY];

  // Shift valid and markers one stage per enabled cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        marker_r[i] <= {MARKER_BITS{1'b0}};
      end
    end else if (cke) begin
      valid_r[0]  <= in_valid;
      marker_r[0] <= in_marker;
      for (int i = 1; i < LATENCY; i++) begin
        valid_r[i]  <= valid_r[i-1];
        marker_r[i] <= marker_r[i-1];
      end
    end
  end

  assign out_valid  = valid_r[LATENCY-1];
  assign out_marker = marker_r[LATENCY-1];
  assign any_valid  = |valid_r;

endmodule

// File: rtl/jelly3_img_demosaic_acpi_seq.sv
// Frame sequencer for the demosaic datapath: handshake, sideband alignment,
// shadowed Bayer phase. Optional counter: JELLY3_IMG_DEMOSAIC_SEQ_FRAME_COUNT_EN.
module jelly3_img_demosaic_acpi_seq
  import jelly3_img_demosaic_pkg::*;
#(
  parameter int LATENCY        = DEFAULT_LATENCY,
  parameter int FRAME_CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [1:0]                param_phase,
  input  logic                      param_update,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      s_line_first,
  input  logic                      s_pixel_first,
  input  logic                      s_last,
  output logic                      dp_cke,
  output logic                      dp_line_first,
  output logic                      dp_pixel_first,
  output logic [1:0]                dp_param_phase,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_line_first,
  output logic                      m_pixel_first,
  output logic                      m_last,
  output logic                      busy,
  output logic [FRAME_CNT_BITS-1:0] frame_count
);

  logic   cke_s;
  logic   accept_s;
  logic   sof_s;
  logic   eof_s;
  logic   pipe_any_s;
  logic   [2:0] marker_in_s;
  logic   [2:0] marker_out_s;
  state_t state_r;
  state_t state_next_s;
  phase_t phase_r;
  logic   busy_r;

  // Output stalls only when a beat is presented and refused
  assign cke_s    = m_ready | ~m_valid;
  assign dp_cke   = cke_s;
  assign s_ready  = cke_s;
  assign accept_s = s_valid & cke_s;
  assign sof_s    = is_frame_start(accept_s, s_line_first, s_pixel_first);
  assign eof_s    = accept_s & s_last;

  assign dp_line_first  = s_valid & s_line_first;
  assign dp_pixel_first = s_valid & s_pixel_first;
  assign marker_in_s    = {dp_line_first, dp_pixel_first, s_valid & s_last};

  jelly3_img_demosaic_sideband_pipe #(
    .LATENCY     (LATENCY),
    .MARKER_BITS (3)
  ) u_sideband_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .cke        (cke_s),
    .in_valid   (s_valid),
    .in_marker  (marker_in_s),
    .out_valid  (m_valid),
    .out_marker (marker_out_s),
    .any_valid  (pipe_any_s)
  );

  assign {m_line_first, m_pixel_first, m_last} = marker_out_s;

  // Next-state: a new frame start always wins over draining the previous one
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sof_s) state_next_s = eof_s ? ST_DRAIN : ST_ACTIVE;
        else       state_next_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (eof_s) state_next_s = ST_DRAIN;
        else       state_next_s = ST_ACTIVE;
      end
      ST_DRAIN: begin
        if (sof_s)            state_next_s = eof_s ? ST_DRAIN : ST_ACTIVE;
        else if (!pipe_any_s) state_next_s = ST_IDLE;
        else                  state_next_s = ST_DRAIN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, busy flag and shadowed phase registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      phase_r <= 2'b00;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      if (sof_s && param_update) phase_r <= param_phase;
    end
  end

  assign busy           = busy_r;
  assign dp_param_phase = phase_r;

`ifdef JELLY3_IMG_DEMOSAIC_SEQ_FRAME_COUNT_EN
  logic [FRAME_CNT_BITS-1:0] frame_count_r;

  // Count frames as their last beat leaves the output port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_r <= {FRAME_CNT_BITS{1'b0}};
    end else if (m_valid && m_ready && m_last) begin
      frame_count_r <= frame_count_r + {{(FRAME_CNT_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign frame_count = frame_count_r;
`else
  assign frame_count = {FRAME_CNT_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_jelly3_img_demosaic_acpi_seq.sv
// Directed self-checking bench for jelly3_img_demosaic_acpi_seq.
`timescale 1ns/1ps
module tb_jelly3_img_demosaic_acpi_seq;

  localparam int FCB = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] param_phase = 2'b00;
  logic param_update = 1'b0;
  logic s_valid = 1'b0, s_line_first = 1'b0, s_pixel_first = 1'b0, s_last = 1'b0;
  logic s_ready, dp_cke, dp_line_first, dp_pixel_first;
  logic [1:0] dp_param_phase;
  logic m_valid, m_line_first, m_pixel_first, m_last, busy;
  logic m_ready = 1'b1;
  logic [FCB-1:0] frame_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jelly3_img_demosaic_acpi_seq #(.LATENCY(7), .FRAME_CNT_BITS(FCB)) dut (
    .clk(clk), .reset_n(reset_n), .param_phase(param_phase), .param_update(param_update),
    .s_valid(s_valid), .s_ready(s_ready), .s_line_first(s_line_first),
    .s_pixel_first(s_pixel_first), .s_last(s_last), .dp_cke(dp_cke),
    .dp_line_first(dp_line_first), .dp_pixel_first(dp_pixel_first),
    .dp_param_phase(dp_param_phase), .m_valid(m_valid), .m_ready(m_ready),
    .m_line_first(m_line_first), .m_pixel_first(m_pixel_first), .m_last(m_last),
    .busy(busy), .frame_count(frame_count)
  );

  typedef struct {
    logic       sv, lf, pf, last;
    logic [3:0] exp_m;     // {m_valid, m_line_first, m_pixel_first, m_last}
    logic       exp_busy;
    int         exp_fc;
  } vec_t;

  typedef struct {
    logic       lf, pf, last;
    logic [1:0] ph;
    logic       upd;
    int         gap;
  } beat_t;

  vec_t       tbl [17];
  beat_t      bq [$];
  logic [2:0] oq [$];

  function automatic int fc_exp(input int n);
`ifdef JELLY3_IMG_DEMOSAIC_SEQ_FRAME_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [1:0] ph_start, input logic upd_start,
                            input logic [1:0] ph_mid, input int gap0, input int gap1);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.lf   = (i < 4);
      b.pf   = (i % 4 == 0);
      b.last = (i == 7);
      b.ph   = (i < 4) ? ph_start : ph_mid;
      b.upd  = (i < 4) ? upd_start : 1'b1;
      b.gap  = (i == 0) ? gap0 : ((i == 1) ? gap1 : 0);
      bq.push_back(b);
    end
  endtask

  // Drive queued beats with handshake, optional output stall, collect output beats
  task automatic run_seq(input int n_cycles, input int stall_at, input int stall_len,
                         input bit chk_busy);
    int idx = 0;
    int gap_cnt = 0;
    bit prev_stall = 1'b0;
    logic [2:0] prev_m = 3'b000;
    oq.delete();
    for (int c = 0; c < n_cycles; c++) begin
      @(posedge clk); #1;
      m_ready = !(c >= stall_at && c < stall_at + stall_len);
      if (idx < bq.size() && gap_cnt >= bq[idx].gap) begin
        s_valid = 1'b1;
        {s_line_first, s_pixel_first, s_last} = {bq[idx].lf, bq[idx].pf, bq[idx].last};
        param_phase  = bq[idx].ph;
        param_update = bq[idx].upd;
      end else begin
        s_valid = 1'b0;
        {s_line_first, s_pixel_first, s_last} = 3'b000;
      end
      @(negedge clk);
      if (m_valid && !m_ready) begin
        check("stall_dp_cke", dp_cke, 1'b0);
        check("stall_s_ready", s_ready, 1'b0);
        if (prev_stall) check("stall_hold", {m_line_first, m_pixel_first, m_last}, prev_m);
        prev_stall = 1'b1;
        prev_m = {m_line_first, m_pixel_first, m_last};
      end else begin
        prev_stall = 1'b0;
      end
      if (m_valid && m_ready) oq.push_back({m_line_first, m_pixel_first, m_last});
      if (chk_busy && idx > 0 && idx < bq.size()) check("busy_hold", busy, 1'b1);
      if (s_valid && s_ready) begin
        idx++;
        gap_cnt = 0;
      end else if (!s_valid) begin
        gap_cnt++;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    {s_line_first, s_pixel_first, s_last} = 3'b000;
    check("beats_accepted", idx, bq.size());
    check("beats_out", oq.size(), bq.size());
    for (int i = 0; i < bq.size() && i < oq.size(); i++)
      check($sformatf("beat_%0d", i), oq[i], {bq[i].lf, bq[i].pf, bq[i].last});
    bq.delete();
  endtask

  initial begin
    // 4x2 frame back-to-back, m_ready held high
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b1110, 1'b1, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b1, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b1, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b1, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b1, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b1, 0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1};

    // Reset state
    #12;
    check("rst_m", {m_valid, m_line_first, m_pixel_first, m_last}, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_fc", frame_count, 32'd0);
    check("rst_phase", dp_param_phase, 2'b00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (9) @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      {s_valid, s_line_first, s_pixel_first, s_last} =
        {tbl[i].sv, tbl[i].lf, tbl[i].pf, tbl[i].last};
      @(negedge clk);
      check($sformatf("tbl_m_%0d", i), {m_valid, m_line_first, m_pixel_first, m_last},
            tbl[i].exp_m);
      check($sformatf("tbl_busy_%0d", i), busy, tbl[i].exp_busy);
      check($sformatf("tbl_fc_%0d", i), frame_count, fc_exp(tbl[i].exp_fc));
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    {s_line_first, s_pixel_first, s_last} = 3'b000;

    // Phase 11 loaded at frame start, mid-frame 01 ignored, output stalled 5 cycles
    push_frame(2'b11, 1'b1, 2'b01, 0, 0);
    run_seq(35, 9, 5, 1'b0);
    check("phase_load", dp_param_phase, 2'b11);
    check("fc_2", frame_count, fc_exp(2));

    // Frame start without update keeps the shadow phase
    push_frame(2'b01, 1'b0, 2'b01, 0, 0);
    run_seq(25, 100, 0, 1'b0);
    check("phase_hold", dp_param_phase, 2'b11);
    check("fc_3", frame_count, fc_exp(3));

    // Frame B starts during A's drain, then pauses long enough to empty the pipe
    push_frame(2'b01, 1'b1, 2'b01, 0, 0);
    push_frame(2'b10, 1'b1, 2'b10, 1, 12);
    run_seq(50, 100, 0, 1'b1);
    check("phase_b", dp_param_phase, 2'b10);
    check("fc_5", frame_count, fc_exp(5));
    check("idle_after_ab", busy, 1'b0);

    // Reset pulse with three beats in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_line_first = 1'b1;
      s_pixel_first = (i == 0);
      param_phase = 2'b01;
      param_update = 1'b1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    {s_line_first, s_pixel_first, s_last} = 3'b000;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("rst2_mvalid_%0d", i), m_valid, 1'b0);
      check($sformatf("rst2_busy_%0d", i), busy, 1'b0);
      @(posedge clk); #1;
    end
    check("rst2_fc", frame_count, 32'd0);
    check("rst2_phase", dp_param_phase, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
